vram_fill: RTL and testbench
============================

Name: vram_fill

Overview:
- Rectangle-fill engine that drives the write port of the VDP's dual-port VRAM.
- Accepts one fill command at a time over a valid/ready handshake. Each command carries x, y, width, height and a 24-bit RGB colour.
- Writes one pixel per clock into the row-major framebuffer, clipped to the screen.
- Sits directly upstream of the VRAM. The vga scan-out reads the same memory from the other port.

Parameters:
- FB_W, 256, framebuffer width in pixels; must be a power of two.
- FB_H, 256, framebuffer height in pixels.
- COORD_W, 8, bit width of the x/y coordinates; equals log2(FB_W).
- ADDR_W, 16, VRAM address width; must be at least log2(FB_W*FB_H).
- DATA_W, 24, pixel width, packed {R[7:0],G[7:0],B[7:0]}.

Ports:
- CLOCK_50  in  1  sole clock. Integration ties vram_wclk to CLOCK_50.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_x  in  COORD_W  left column.
- cmd_y  in  COORD_W  top row.
- cmd_w  in  COORD_W+1  width in pixels; 0 is legal.
- cmd_h  in  COORD_W+1  height in pixels; 0 is legal.
- cmd_color  in  DATA_W  fill colour.
- vram_wadr  out  ADDR_W  VRAM write address.
- vram_d  out  DATA_W  VRAM write data.
- vram_we  out  1  VRAM write enable.
- busy  out  1  high from command accept until done.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- All outputs are registered.
- Reset values: cmd_ready=1, vram_we=0, vram_wadr=0, vram_d=0, busy=0, done=0.
- Accept: a command is accepted at the edge where cmd_valid and cmd_ready are both 1 (cycle T). cmd_ready is high only in IDLE. All cmd_* fields are captured at accept; later changes to them are ignored.
- IDLE: waits for accept, then goes to SETUP. busy is 1 from T+1.
- SETUP (one cycle):
  - Clipped width: ew = min(cmd_w, FB_W-cmd_x), or 0 if cmd_x >= FB_W. Clipped height eh is computed the same way from cmd_h, cmd_y and FB_H.
  - Arithmetic is done in COORD_W+1 bits.
  - row_base = (cmd_y << log2(FB_W)) + cmd_x, computed ADDR_W wide. No multiplier is used.
  - If ew==0 or eh==0, go to DONE; otherwise go to FILL.
- FILL:
  - First write appears in cycle T+2: vram_we=1, vram_wadr=row_base, vram_d=colour.
  - Each subsequent cycle writes the next pixel. Address increments by 1 within a row.
  - After the last pixel of a row: row_base += FB_W and the column resets to 0.
  - Exactly ew*eh consecutive cycles carry vram_we=1, with no gaps. After the last write, go to DONE.
  - vram_wadr and vram_d are held when vram_we=0.
- DONE (one cycle): done=1, vram_we=0. busy is still 1 in this cycle. Next state is IDLE, where cmd_ready=1 and busy=0.
- Back-to-back: a cmd_valid held high is accepted in the first IDLE cycle after DONE. Minimum command period is ew*eh+3 cycles.
- Address arithmetic wraps modulo 2^ADDR_W. Clipping guarantees no write outside FB_W x FB_H.
- Reset mid-operation: the next cycle is IDLE with vram_we=0 and done=0. No further writes occur and the command is dropped.
- No reads are performed. Write/scan-out tearing is the software's concern.

Decomposition:
- Package vdp_pkg holds:
  - FB_W, FB_H, COORD_W, ADDR_W, DATA_W defaults.
  - typedef rgb_t: packed struct {r, g, b}, 8 bits each.
  - typedef fill_cmd_t: {x, y, w, h, color}.
  - enum fill_state_t: {IDLE, SETUP, FILL, DONE}.
- Single module; no sub-module needed. Clipping logic stays inline as a function in the package.

Test Plan:
- Basic fill: x=10, y=20, w=3, h=2, colour 0xFF0000, accept at T.
  - Required: writes in cycles T+2..T+7 to addresses 5130, 5131, 5132, 5386, 5387, 5388, all with data 0xFF0000.
  - done at T+8; cmd_ready at T+9.
- Clip: x=254, y=255, w=5, h=3, colour 0x00FF00.
  - Required: exactly 2 writes, to 65534 and 65535, then done.
- Empty commands: w=0 (and separately x=300 is unrepresentable, so use h=0).
  - Required: no vram_we; done at T+2.
- Full screen: x=0, y=0, w=256, h=256, colour 0x0000FF.
  - Required: 65536 contiguous writes covering addresses 0..65535 in order; done exactly 1 cycle after the last write.
- Back-to-back: cmd_valid held with 1x1 at (0,0), then 1x1 at (1,0).
  - Required: first write at T+2, done at T+3, second accept at T+4, second write (address 1) at T+6.
- Reset mid-fill: reset asserted for 1 cycle during the 4th write of a 4x4 fill.
  - Required: vram_we=0 from the next cycle, no done pulse, cmd_ready=1, and a new command afterwards is accepted normally.

Source files
------------

// File: rtl/vdp_pkg.sv
// Shared VDP definitions: framebuffer geometry defaults, fill command types
// and the clip helper used by the rectangle-fill engine.
package vdp_pkg;

  localparam int unsigned FB_W    = 256;
  localparam int unsigned FB_H    = 256;
  localparam int unsigned COORD_W = 8;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W:0]   w;
    logic [COORD_W:0]   h;
    rgb_t               color;
  } fill_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    FILL,
    DONE
  } fill_state_t;

  // Length of a span starting at pos, clipped to [0, lim). Callers truncate the
  // result to COORD_W+1 bits; every value involved fits in that width.
  function automatic int unsigned clip_len(input int unsigned len, input int unsigned pos,
                                           input int unsigned lim);
    int unsigned room;
    if (pos >= lim) return 0;
    room = lim - pos;
    return (len < room) ? len : room;
  endfunction

endpackage

// File: rtl/vram_fill_if.sv
// Command handshake plus VRAM write port of the fill engine.
// slave: the fill engine; master: whoever issues commands and observes writes.
interface vram_fill_if
  import vdp_pkg::*;
#(
  parameter int unsigned CoordW = vdp_pkg::COORD_W,
  parameter int unsigned AddrW  = vdp_pkg::ADDR_W,
  parameter int unsigned DataW  = vdp_pkg::DATA_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [CoordW-1:0] cmd_x;
  logic [CoordW-1:0] cmd_y;
  logic [CoordW:0]   cmd_w;
  logic [CoordW:0]   cmd_h;
  logic [DataW-1:0]  cmd_color;
  logic [AddrW-1:0]  vram_wadr;
  logic [DataW-1:0]  vram_d;
  logic              vram_we;

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready, vram_wadr, vram_d, vram_we
  );

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready, vram_wadr, vram_d, vram_we
  );

endinterface

// File: rtl/vram_fill.sv
// Rectangle-fill engine: takes one fill command at a time and writes one
// clipped pixel per clock into the row-major framebuffer via the VRAM write port.
module vram_fill #(
  parameter int unsigned FB_W    = vdp_pkg::FB_W,
  parameter int unsigned FB_H    = vdp_pkg::FB_H,
  parameter int unsigned COORD_W = vdp_pkg::COORD_W,
  parameter int unsigned ADDR_W  = vdp_pkg::ADDR_W,
  parameter int unsigned DATA_W  = vdp_pkg::DATA_W
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  vram_fill_if.slave  bus,
  output logic        busy,
  output logic        done
);

  import vdp_pkg::*;

  localparam int unsigned        XShift  = $clog2(FB_W);
  localparam logic [ADDR_W-1:0]  RowStep = ADDR_W'(FB_W);
  localparam logic [COORD_W:0]   One     = (COORD_W+1)'(1);

  fill_state_t        state_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic [COORD_W:0]   w_q, h_q;
  logic [DATA_W-1:0]  color_q;
  logic [COORD_W:0]   ew_q, eh_q;
  logic [COORD_W:0]   col_q, row_q;
  logic [ADDR_W-1:0]  row_base_q;
  logic [ADDR_W-1:0]  wadr_q;
  logic [DATA_W-1:0]  d_q;
  logic               we_q, busy_q, done_q, ready_q;

  logic [COORD_W:0]   ew_c, eh_c;
  logic [ADDR_W-1:0]  base_c;
  logic               last_col, last_row;

  // Clipped extents and first-row address from the captured command (used in SETUP).
  always_comb begin
    ew_c     = (COORD_W+1)'(clip_len(32'(w_q), 32'(x_q), FB_W));
    eh_c     = (COORD_W+1)'(clip_len(32'(h_q), 32'(y_q), FB_H));
    // Shift instead of multiply: FB_W is a power of two.
    base_c   = (ADDR_W'(y_q) << XShift) + ADDR_W'(x_q);
    last_col = (col_q == ew_q - One);
    last_row = (row_q == eh_q - One);
  end

  // Control FSM with all outputs registered; col_q/row_q track the pixel on the bus.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      ew_q       <= '0;
      eh_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      wadr_q     <= '0;
      d_q        <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid && ready_q) begin
            x_q     <= bus.cmd_x;
            y_q     <= bus.cmd_y;
            w_q     <= bus.cmd_w;
            h_q     <= bus.cmd_h;
            color_q <= bus.cmd_color;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          ew_q       <= ew_c;
          eh_q       <= eh_c;
          col_q      <= '0;
          row_q      <= '0;
          row_base_q <= base_c;
          if (ew_c == '0 || eh_c == '0) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            we_q    <= 1'b1;
            wadr_q  <= base_c;
            d_q     <= color_q;
            state_q <= FILL;
          end
        end
        FILL: begin
          if (last_col) begin
            col_q <= '0;
            if (last_row) begin
              we_q    <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              row_q      <= row_q + One;
              row_base_q <= row_base_q + RowStep;
              wadr_q     <= row_base_q + RowStep;
            end
          end else begin
            col_q  <= col_q + One;
            wadr_q <= wadr_q + ADDR_W'(1);
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.vram_wadr = wadr_q;
  assign bus.vram_d    = d_q;
  assign bus.vram_we   = we_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_vram_fill.sv
// Scoreboard bench for vram_fill: the stimulus side queues expected writes and
// done pulses (with their cycle numbers); a monitor pops them as the DUT emits.
module tb_vram_fill;
  import vdp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, done;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int cyc;
    int adr;
    int d;
  } exp_wr_t;

  exp_wr_t exp_wr[$];
  int      exp_done[$];

  vram_fill_if bus ();

  vram_fill dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus.slave),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write and every done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (bus.vram_we === 1'b1) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: adr %0h data %0h at cycle %0d, none expected",
                 bus.vram_wadr, bus.vram_d, cyc);
      end else begin
        exp_wr_t e;
        e = exp_wr.pop_front();
        chk("wr_cycle", cyc, e.cyc);
        chk("wr_adr", 32'(bus.vram_wadr), e.adr);
        chk("wr_data", 32'(bus.vram_d), e.d);
      end
    end
    if (done === 1'b1) begin
      if (exp_done.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done at cycle %0d, none expected", cyc);
      end else begin
        chk("done_cycle", cyc, exp_done.pop_front());
      end
    end
  end

  // Wait for the next negedge, then until the cycle counter reaches c.
  task automatic at(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  // Issue one command; t returns the cycle T whose closing edge accepts it.
  // stop_after >= 0 queues only that many writes and no done (reset mid-fill).
  task automatic send(input int x, input int y, input int w, input int h, input int color,
                      input bit hold, input int stop_after, output int t);
    int ew, eh, n, b;
    @(negedge clk);
    bus.cmd_x     = 8'(x);
    bus.cmd_y     = 8'(y);
    bus.cmd_w     = 9'(w);
    bus.cmd_h     = 9'(h);
    bus.cmd_color = 24'(color);
    bus.cmd_valid = 1'b1;
    b = 0;
    while (bus.cmd_ready !== 1'b1 && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (b >= 100) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: cmd_ready %b after %0d cycles, need 1", bus.cmd_ready, b);
    end
    t  = cyc;
    ew = (w < 256 - x) ? w : 256 - x;
    eh = (h < 256 - y) ? h : 256 - y;
    n  = 0;
    for (int r = 0; r < eh; r++) begin
      for (int c = 0; c < ew; c++) begin
        if (stop_after < 0 || n < stop_after) begin
          exp_wr.push_back('{cyc: t + 2 + n, adr: ((y + r) * 256 + x + c) & 'hFFFF,
                             d: color});
        end
        n++;
      end
    end
    if (stop_after < 0) exp_done.push_back(t + 2 + ew * eh);
    @(posedge clk);
    #1;
    if (!hold) begin
      bus.cmd_valid = 1'b0;
      // Fields are captured at accept; garbage afterwards must not matter.
      bus.cmd_x     = 8'($urandom);
      bus.cmd_y     = 8'($urandom);
      bus.cmd_w     = 9'($urandom);
      bus.cmd_h     = 9'($urandom);
      bus.cmd_color = 24'($urandom);
    end
  endtask

  task automatic wait_idle(input int limit);
    int b = 0;
    while ((exp_wr.size() != 0 || exp_done.size() != 0) && b < limit) begin
      @(negedge clk);
      b++;
    end
    if (b >= limit) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d writes and %0d done pulses still pending",
               exp_wr.size(), exp_done.size());
    end
    @(negedge clk);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t1, t2;
    bus.cmd_valid = 1'b0;
    bus.cmd_x     = '0;
    bus.cmd_y     = '0;
    bus.cmd_w     = '0;
    bus.cmd_h     = '0;
    bus.cmd_color = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.cmd_ready), 1);
    chk("rst_we", 32'(bus.vram_we), 0);
    chk("rst_wadr", 32'(bus.vram_wadr), 0);
    chk("rst_d", 32'(bus.vram_d), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;

    // Basic 3x2 fill at (10,20).
    send(10, 20, 3, 2, 'hFF0000, 1'b0, -1, t);
    at(t + 1);
    chk("basic_busy_t1", 32'(busy), 1);
    chk("basic_ready_t1", 32'(bus.cmd_ready), 0);
    at(t + 8);
    chk("basic_busy_done", 32'(busy), 1);
    chk("basic_ready_done", 32'(bus.cmd_ready), 0);
    at(t + 9);
    chk("basic_ready_t9", 32'(bus.cmd_ready), 1);
    chk("basic_busy_t9", 32'(busy), 0);
    wait_idle(100);

    // Clipped at the bottom-right corner: 2x1 remains.
    send(254, 255, 5, 3, 'h00FF00, 1'b0, -1, t);
    wait_idle(100);

    // Empty commands.
    send(7, 9, 0, 5, 'h123456, 1'b0, -1, t);
    wait_idle(100);
    send(100, 3, 4, 0, 'h654321, 1'b0, -1, t);
    wait_idle(100);

    // Full screen.
    send(0, 0, 256, 256, 'h0000FF, 1'b0, -1, t);
    wait_idle(70000);

    // Back-to-back with cmd_valid held across both.
    send(0, 0, 1, 1, 'hABCDEF, 1'b1, -1, t1);
    send(1, 0, 1, 1, 'h0F0F0F, 1'b0, -1, t2);
    chk("b2b_accept_cycle", t2, t1 + 4);
    wait_idle(100);

    // Reset for one cycle during the 4th write of a 4x4 fill.
    send(0, 0, 4, 4, 'h777777, 1'b0, 4, t);
    at(t + 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    at(t + 6);
    chk("rst_mid_we", 32'(bus.vram_we), 0);
    chk("rst_mid_done", 32'(done), 0);
    chk("rst_mid_ready", 32'(bus.cmd_ready), 1);
    chk("rst_mid_busy", 32'(busy), 0);
    repeat (20) @(negedge clk);

    // Normal command after the aborted one.
    send(3, 4, 2, 2, 'h123456, 1'b0, -1, t);
    wait_idle(100);

    chk("leftover_writes", exp_wr.size(), 0);
    chk("leftover_done", exp_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
